// File: rtl/demux_deser.sv
// Serial-to-parallel collector: one bit per d handshake lands at z[sel], and the
// finished WIDTH-bit word is offered downstream on a z_vld/z_rdy handshake.
module demux_deser #(
    parameter int WIDTH = 512,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             d,
    input  logic             d_vld,
    output logic             d_rdy,
    output logic [WIDTH-1:0] z,
    output logic             z_vld,
    input  logic             z_rdy,
    output logic [SEL_W-1:0] sel
);

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t state;
    logic   accept;

    // A full word can accept the first bit of the next word on the hand-off edge.
    always_comb begin
        d_rdy = 1'b1;
        if (state == FULL) d_rdy = z_rdy;
    end

    assign accept = d_vld && d_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            z     <= '0;
            z_vld <= 1'b0;
            sel   <= '0;
        end else if (clr) begin
            // z keeps its contents; the next word start overwrites all of it.
            state <= IDLE;
            z_vld <= 1'b0;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        z     <= {{(WIDTH-1){1'b0}}, d};
                        sel   <= SEL_W'(1);
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        z[sel] <= d;
                        sel    <= sel + SEL_W'(1);
                        if (sel == SEL_W'(WIDTH-1)) begin
                            z_vld <= 1'b1;
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (z_rdy) begin
                        z_vld <= 1'b0;
                        if (d_vld) begin
                            z     <= {{(WIDTH-1){1'b0}}, d};
                            sel   <= SEL_W'(1);
                            state <= FILL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_deser.sv
// Directed vector table on an 8-bit collector, hand sequences for streaming and
// async reset, and a randomly stalled 512-bit stream against a bit scoreboard.
module tb_demux_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0, d = 1'b0, d_vld = 1'b0, z_rdy = 1'b0;
    logic       d_rdy, z_vld;
    logic [7:0] z;
    logic [2:0] sel;

    logic         b_clr = 1'b0, b_d = 1'b0, b_d_vld = 1'b0, b_z_rdy = 1'b0;
    logic         b_d_rdy, b_z_vld;
    logic [511:0] b_z;
    logic [8:0]   b_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_deser #(.WIDTH(8), .SEL_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .d(d), .d_vld(d_vld), .d_rdy(d_rdy),
        .z(z), .z_vld(z_vld), .z_rdy(z_rdy), .sel(sel)
    );

    demux_deser #(.WIDTH(512), .SEL_W(9)) u_big (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .d(b_d), .d_vld(b_d_vld), .d_rdy(b_d_rdy),
        .z(b_z), .z_vld(b_z_vld), .z_rdy(b_z_rdy), .sel(b_sel)
    );

    typedef struct {
        logic       clr;
        logic       d;
        logic       dv;
        logic       zr;
        logic [7:0] ez;
        logic       evld;
        logic [2:0] esel;
        logic       erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic dd, input logic dv, input logic zr,
                       input logic [7:0] ez, input logic ev, input logic [2:0] es, input logic er);
        vec_t v;
        v.clr = c; v.d = dd; v.dv = dv; v.zr = zr;
        v.ez = ez; v.evld = ev; v.esel = es; v.erdy = er;
        vecs.push_back(v);
    endtask

    task automatic chk_small(input string tag, input logic [7:0] ez, input logic ev,
                             input logic [2:0] es, input logic er);
        chk({tag, ".z"}, 32'(z), 32'(ez));
        chk({tag, ".z_vld"}, 32'(z_vld), 32'(ev));
        chk({tag, ".sel"}, 32'(sel), 32'(es));
        chk({tag, ".d_rdy"}, 32'(d_rdy), 32'(er));
    endtask

    task automatic drive(input logic c, input logic dd, input logic dv, input logic zr);
        clr = c; d = dd; d_vld = dv; z_rdy = zr;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [7:0]   words [3];
    logic [511:0] cur, exp_z;
    logic         exp_vld, acc, xfer, newword;
    int           cnt, nwords, cyc;

    initial begin
        // Reset values, then the first-word / partial / CLR directed table.
        #3;
        chk_small("reset_hold", 8'h00, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_small("reset_rel", 8'h00, 1'b0, 3'd0, 1'b1);

        // 1,0,1,1,0,0,1,0 with z_rdy low
        add(0,1,1,0, 8'h01,0,3'd1,1); add(0,0,1,0, 8'h01,0,3'd2,1);
        add(0,1,1,0, 8'h05,0,3'd3,1); add(0,1,1,0, 8'h0D,0,3'd4,1);
        add(0,0,1,0, 8'h0D,0,3'd5,1); add(0,0,1,0, 8'h0D,0,3'd6,1);
        add(0,1,1,0, 8'h4D,0,3'd7,1); add(0,0,1,0, 8'h4D,1,3'd0,0);
        add(0,'x,0,0, 8'h4D,1,3'd0,0); add(0,1,1,0, 8'h4D,1,3'd0,0);
        add(0,'x,0,0, 8'h4D,1,3'd0,0); add(0,'x,0,0, 8'h4D,1,3'd0,0);
        add(0,'x,0,0, 8'h4D,1,3'd0,0);
        add(0,'x,0,1, 8'h4D,0,3'd0,1);
        // partial word, idle gap with X on d, resume with zeros
        add(0,1,1,0, 8'h01,0,3'd1,1); add(0,1,1,0, 8'h03,0,3'd2,1);
        add(0,1,1,0, 8'h07,0,3'd3,1);
        for (int i = 0; i < 4; i++) add(0,'x,0,0, 8'h07,0,3'd3,1);
        add(0,0,1,0, 8'h07,0,3'd4,1); add(0,0,1,0, 8'h07,0,3'd5,1);
        add(0,0,1,0, 8'h07,0,3'd6,1); add(0,0,1,0, 8'h07,0,3'd7,1);
        add(0,0,1,0, 8'h07,1,3'd0,0);
        add(0,'x,0,1, 8'h07,0,3'd0,1);
        // CLR after 5 bits, then 0xF0 with no residue
        add(0,1,1,0, 8'h01,0,3'd1,1); add(0,0,1,0, 8'h01,0,3'd2,1);
        add(0,1,1,0, 8'h05,0,3'd3,1); add(0,0,1,0, 8'h05,0,3'd4,1);
        add(0,1,1,0, 8'h15,0,3'd5,1);
        add(1,'x,0,0, 8'h15,0,3'd0,1);
        add(0,0,1,0, 8'h00,0,3'd1,1); add(0,0,1,0, 8'h00,0,3'd2,1);
        add(0,0,1,0, 8'h00,0,3'd3,1); add(0,0,1,0, 8'h00,0,3'd4,1);
        add(0,1,1,0, 8'h10,0,3'd5,1); add(0,1,1,0, 8'h30,0,3'd6,1);
        add(0,1,1,0, 8'h70,0,3'd7,1); add(0,1,1,0, 8'hF0,1,3'd0,0);
        // CLR beats a transfer-with-accept in FULL
        add(1,1,1,1, 8'hF0,0,3'd0,1);
        // bit presented alongside CLR is dropped
        add(0,1,1,0, 8'h01,0,3'd1,1);
        add(1,1,1,0, 8'h01,0,3'd0,1);
        add(0,0,1,0, 8'h00,0,3'd1,1);
        add(1,'x,0,0, 8'h00,0,3'd0,1);
        // z_rdy in IDLE is ignored
        add(0,'x,0,1, 8'h00,0,3'd0,1);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].d, vecs[i].dv, vecs[i].zr);
            chk_small($sformatf("vec%0d", i), vecs[i].ez, vecs[i].evld, vecs[i].esel, vecs[i].erdy);
        end

        // Back-to-back words with z_rdy held high: no bubble, no lost bit.
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] w;
            w = words[i / 8];
            drive(1'b0, w[i % 8], 1'b1, 1'b1);
            chk($sformatf("stream%0d.d_rdy", i), 32'(d_rdy), 32'd1);
            chk($sformatf("stream%0d.sel", i), 32'(sel), 32'((i + 1) % 8));
            chk($sformatf("stream%0d.z_vld", i), 32'(z_vld), 32'(i % 8 == 7));
            if (i % 8 == 7) chk($sformatf("stream%0d.z", i), 32'(z), 32'(w));
        end
        drive(1'b0, 1'bx, 1'b0, 1'b1);
        chk_small("stream_end", 8'hFF, 1'b0, 3'd0, 1'b1);

        // Async reset mid-word at sel=4, taking effect between edges.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk_small("pre_rst_fill", 8'h0F, 1'b0, 3'd4, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_small("rst_fill", 8'h00, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        d_vld = 1'b0;
        @(negedge clk);
        chk_small("rst_fill_rel", 8'h00, 1'b0, 3'd0, 1'b1);

        // Async reset while holding a full word.
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk_small("pre_rst_full", 8'hFF, 1'b1, 3'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_small("rst_full", 8'h00, 1'b0, 3'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        d_vld = 1'b0;
        @(negedge clk);
        chk_small("rst_full_rel", 8'h00, 1'b0, 3'd0, 1'b1);

        // 512-bit stream with random stalls on both sides, 20 words.
        cnt = 0; nwords = 0; cyc = 0; exp_vld = 1'b0; cur = '0; exp_z = '0;
        while (nwords < 20 && cyc < 40000) begin
            b_d_vld = ($urandom_range(0, 9) < 8);
            b_d     = b_d_vld ? 1'($urandom_range(0, 1)) : 1'bx;
            b_z_rdy = ($urandom_range(0, 9) < 3);
            #1;
            acc  = b_d_vld && b_d_rdy;
            xfer = exp_vld && b_z_rdy;
            newword = 1'b0;
            if (xfer) exp_vld = 1'b0;
            if (acc) begin
                if (cnt == 0) cur = '0;
                cur[cnt] = b_d;
                cnt = (cnt + 1) % 512;
                if (cnt == 0) begin
                    exp_vld = 1'b1;
                    exp_z   = cur;
                    newword = 1'b1;
                    nwords++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            chk("big.z_vld", 32'(b_z_vld), 32'(exp_vld));
            chk("big.sel", 32'(b_sel), 32'(cnt));
            if (newword) begin
                checks++;
                if (b_z !== exp_z) begin
                    errors++;
                    $display("FAIL big.z word %0d: got %h expected %h", nwords, b_z, exp_z);
                end
            end
        end
        chk("big.word_count", 32'(nwords), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
